imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Fetch sequencer that drives the simulation instruction memory through its valid/ready request port.
- Owns the fetch PC and issues sequential word fetches.
- Buffers fetched {pc, inst} pairs in a small queue and presents them to decode over a valid/ready handshake.
- Sits between the instruction memory and decode; handles redirects (branch/jump/trap) and halt.

Parameters:
- ADDR_WIDTH, 32, fetch PC / memory address width.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- DEPTH, 2, fetch queue entries (power of two, ≥2).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_valid  out  1  fetch request valid.
- mem_ready  in  1  memory accepts request; instruction returned same cycle.
- mem_pc  out  ADDR_WIDTH  request address.
- mem_inst  in  INST_WIDTH  instruction for mem_pc, valid when mem_valid&&mem_ready.
- out_valid  out  1  queue head valid to decode.
- out_ready  in  1  decode accepts head.
- out_pc  out  ADDR_WIDTH  PC of head entry.
- out_inst  out  INST_WIDTH  instruction of head entry.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  new fetch target.
- halt  in  1  stop issuing fetches (sticky until reset).
- halted  out  1  in HALT state and queue empty.

Behaviour:
- Reset (sync, active-high, clock): state=IDLE, pc=RESET_PC, count=0.
  - All outputs 0 except mem_pc=RESET_PC.
  - Reset mid-operation discards queue contents and any in-flight request the same edge.
- FSM states:
  - IDLE → RUN unconditionally on the first cycle after reset deasserts. No requests are issued in IDLE.
  - RUN: mem_valid=1 iff count<DEPTH and !redirect_valid. RUN → HALT when halt=1.
  - HALT: mem_valid=0. Stays in HALT until reset.
- mem_pc = pc, combinationally.
- On accept (mem_valid&&mem_ready): push {pc, mem_inst}, then pc <= pc + 4 modulo 2^ADDR_WIDTH (wraps to 0).
- Latency: request accepted in cycle N → out_valid=1 in N+1 if the queue was empty.
- Queue:
  - Registered FIFO; out_valid = count!=0.
  - out_pc/out_inst come from the head entry and are held stable while out_valid && !out_ready.
- Full: no push when count==DEPTH, even if a pop happens in the same cycle (no bypass, no same-cycle refill).
- Empty: out_valid=0; out_pc/out_inst hold their last value.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
- Redirect (RUN or HALT):
  - Next edge: count=0, pc=redirect_pc with bits[1:0] forced to 0.
  - No request is issued in the redirect cycle.
  - A head popped in the same cycle (out_valid&&out_ready) counts as delivered.
  - In HALT, redirect updates pc and flushes, but the FSM stays in HALT.
  - In IDLE, redirect is ignored.
- halt and redirect in the same cycle: both take effect (flush, pc load, enter HALT).
- halted = (state==HALT) && count==0, registered view of state/count.
- mem_ready=0 while mem_valid=1: request is held with the same mem_pc until accepted or redirected.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping on overflow.
  - perf_fetch_cnt increments on each accepted request.
  - perf_stall_cnt increments each RUN cycle with count==DEPTH.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package imem_fetch_pkg:
  - state enum {IDLE, RUN, HALT}.
  - INST_BYTES=4.
  - Queue entry struct {pc, inst}.
- One sub-module: imem_fetch_queue, a sync FIFO with DEPTH and entry type, and push/pop/flush/count ports.

Test Plan:
- Reset release, mem_ready=1, out_ready=1 → requests at 0x80000000, 0x80000004, 0x80000008 on consecutive cycles. Each appears on out_pc one cycle later with the matching inst.
- out_ready=0 → exactly DEPTH=2 entries accepted, then mem_valid=0 and perf_stall_cnt rising. Release out_ready → entries delivered in order, fetch resumes at 0x80000008.
- Redirect to 0x80001003 while queue holds 2 entries → next cycle out_valid=0, then mem_pc=0x80001000. Stale entries never delivered.
- mem_ready=0 for 3 cycles → mem_pc stays 0x80000000 and mem_valid stays 1. Accept on cycle 4 → single push.
- pc=0xFFFFFFFC accepted → next mem_pc=0x00000000.
- halt asserted with 2 queued entries → no further requests; halted=1 one cycle after the second pop. Reset mid-HALT → IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states, fetch granule
// and the default {pc, inst} queue entry layout.
package imem_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_e;

  localparam int INST_BYTES = 4;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_INST_WIDTH = 32;

  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0] pc;
    logic [DEFAULT_INST_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_queue.sv
// Synchronous FIFO holding fetched entries between instruction memory and decode.
// The head output keeps its last value while the queue is empty.
module imem_fetch_queue
  import imem_fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           last_q, last_d;
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);

    if (count_q != '0) last_d = mem_q[rd_ptr_q];

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues word fetches, queues {pc, inst} for decode.
// Optional performance counters are enabled with the IMEM_FETCH_PERF_EN macro.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    DEPTH      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_pc,
  input  logic [INST_WIDTH-1:0] mem_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  halted
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]      count;
  entry_t                head;
  entry_t                push_data;
  logic                  full, flush, accept, pop;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    full      = (count == CNT_W'(DEPTH));
    flush     = redirect_valid && (state_q != IDLE);
    mem_valid = (state_q == RUN) && !redirect_valid && !full;
    accept    = mem_valid && mem_ready;
    pop       = out_valid && out_ready;

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt) state_d = HALT;
      default: ;
    endcase

    // Redirect targets are forced to a word boundary.
    if (flush)       pc_d = redirect_pc & ~ADDR_WIDTH'(INST_BYTES - 1);
    else if (accept) pc_d = pc_q + ADDR_WIDTH'(INST_BYTES);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign push_data = '{pc: pc_q, inst: mem_inst};

  imem_fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count)
  );

  assign mem_pc    = pc_q;
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign halted    = (state_q == HALT) && (count == '0);

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (accept)                   perf_fetch_d = perf_fetch_q + 32'd1;
    if ((state_q == RUN) && full) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a queue-based reference model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_imem_fetch_ctrl;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b0;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        mem_valid, out_valid, halted;
  logic [31:0] mem_pc, mem_inst, out_pc, out_inst;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  logic [31:0] salt = 32'h1357_9bdf;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ salt;
  endfunction

  // Instruction memory: answers the current request address combinationally.
  assign mem_inst = inst_of(mem_pc);

  imem_fetch_ctrl #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .RESET_PC   (RESET_PC),
    .DEPTH      (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_pc         (mem_pc),
    .mem_inst       (mem_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Reference model
  typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;
  typedef struct packed {
    logic        mv;
    logic [31:0] mpc;
    logic        ov;
    logic [31:0] opc;
    logic [31:0] oinst;
    logic        hd;
    logic [31:0] pf;
    logic [31:0] ps;
  } exp_t;

  mstate_e     m_st = M_IDLE;
  logic [31:0] m_pc = RESET_PC;
  pair_t       m_q[$];
  pair_t       m_last = '0;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_stall = '0;
  exp_t        exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic logic model_req();
    return (m_st == M_RUN) && !redirect_valid && (m_q.size() < DEPTH);
  endfunction

  // Applies the inputs that were present across the edge just taken.
  task automatic model_step();
    logic req;
    if (reset) begin
      m_st = M_IDLE;
      m_pc = RESET_PC;
      m_q.delete();
      m_last  = '0;
      m_fetch = '0;
      m_stall = '0;
      return;
    end
    req = model_req();
    if (req && mem_ready) m_fetch++;
    if (m_st == M_RUN && m_q.size() == DEPTH) m_stall++;
    if (m_q.size() > 0) m_last = m_q[0];
    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
    if (m_st != M_IDLE && redirect_valid) begin
      m_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (req && mem_ready) begin
      m_q.push_back('{pc: m_pc, inst: inst_of(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    if (m_st == M_IDLE) m_st = M_RUN;
    else if (m_st == M_RUN && halt) m_st = M_HALT;
  endtask

  task automatic push_expect();
    exp_t e;
    e.mv  = model_req();
    e.mpc = m_pc;
    e.ov  = (m_q.size() > 0);
    if (e.ov) begin
      e.opc   = m_q[0].pc;
      e.oinst = m_q[0].inst;
    end else begin
      e.opc   = m_last.pc;
      e.oinst = m_last.inst;
    end
    e.hd = (m_st == M_HALT) && (m_q.size() == 0);
    e.pf = m_fetch;
    e.ps = m_stall;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic mr, input logic ordy,
                       input logic rv, input logic [31:0] rpc, input logic h);
    @(posedge clock);
    #1;
    model_step();
    reset          = rst;
    mem_ready      = mr;
    out_ready      = ordy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    push_expect();
  endtask

  // Monitor: compares each cycle's prediction away from the active edge.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mem_valid", 64'(mem_valid), 64'(e.mv));
      check("mem_pc",    64'(mem_pc),    64'(e.mpc));
      check("out_valid", 64'(out_valid), 64'(e.ov));
      check("out_pc",    64'(out_pc),    64'(e.opc));
      check("out_inst",  64'(out_inst),  64'(e.oinst));
      check("halted",    64'(halted),    64'(e.hd));
`ifdef IMEM_FETCH_PERF_EN
      check("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(e.pf));
      check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(e.ps));
`endif
    end
  end

  initial begin
    logic        r_rst, r_mr, r_or, r_rv, r_h;
    logic [31:0] r_pc;
    salt = $urandom;

    // Reset held, then streaming with both sides ready.
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    repeat (6) cycle(0, 1, 1, 0, 0, 0);

    // Back-pressure from decode fills the queue and stalls fetch.
    cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    repeat (6) cycle(0, 1, 0, 0, 0, 0);
    repeat (5) cycle(0, 1, 1, 0, 0, 0);

    // Redirect to an unaligned target with a full queue.
    repeat (4) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 32'h8000_1003, 0);
    repeat (5) cycle(0, 1, 1, 0, 0, 0);

    // Memory stall from reset: request held, then a single accept.
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    repeat (3) cycle(0, 0, 1, 0, 0, 0);

    // PC wrap at the top of the address space.
    cycle(0, 1, 1, 1, 32'hFFFF_FFFE, 0);
    repeat (4) cycle(0, 1, 1, 0, 0, 0);

    // Halt with a full queue, drain, redirect in HALT, then reset out of HALT.
    repeat (4) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1);
    repeat (3) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    repeat (3) cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 32'h0000_0100, 0);
    repeat (2) cycle(0, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    repeat (3) cycle(0, 1, 1, 0, 0, 0);

    // Simultaneous halt and redirect.
    cycle(0, 1, 0, 1, 32'h0000_2000, 1);
    repeat (3) cycle(0, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_mr  = ($urandom_range(0, 3) != 0);
      r_or  = ($urandom_range(0, 2) != 0);
      r_rv  = ($urandom_range(0, 19) == 0);
      r_h   = ($urandom_range(0, 149) == 0);
      r_pc  = $urandom_range(0, 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(r_rst, r_mr, r_or, r_rv, r_pc, r_h);
    end

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
